branch_target_buffer: RTL and testbench

- Fetch-side branch predictor and branch target buffer (BTB). It is the consumer of the execute-stage branch/jump resolution outputs and the producer of the predicted-taken bit that travels down the pipe to EX.
- Lookup is combinational on the IF PC. Training is a registered write from the EX resolution port.
- Direct-mapped, one entry per index: valid bit, tag, target, 2-bit saturating counter.

---
 rtl/branch_target_buffer.sv | 72 +++++++
 tb/tb_branch_target_buffer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating counters.
// Lookup is combinational on the fetch PC; training is a registered write from EX.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_if,
  output logic             btb_hit_if,
  output logic             predicted_taken_if,
  output logic [31:0]      predicted_target_if,
  input  logic             update_btb_ex,
  input  logic [31:0]      pc_ex,
  input  logic             ex_branch_taken,
  input  logic [31:0]      jump_addr_ex,
  input  logic             is_jump_ex,
  input  logic             modify_pc_ex,
  input  logic             flush_btb,
  output logic [CNT_W-1:0] perf_updates,
  output logic [CNT_W-1:0] perf_mispredicts
);
  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - INDEX_W;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];
  logic [INDEX_W-1:0] idx, u;
  logic [TAG_W-1:0]   tag_if, tag_ex;
  logic               u_hit;
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};
  assign idx = pc_if[INDEX_W+1:2];
  assign tag_if = pc_if[31:INDEX_W+2];
  assign u = pc_ex[INDEX_W+1:2];
  assign tag_ex = pc_ex[31:INDEX_W+2];
  assign u_hit = valid[u] && tags[u] == tag_ex;
  assign btb_hit_if = valid[idx] && tags[idx] == tag_if;
  assign predicted_taken_if = btb_hit_if && ctrs[idx][1];
  assign predicted_target_if = btb_hit_if ? targets[idx] : 32'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        targets[i] <= '0;
        ctrs[i] <= 2'b01;
      end
      perf_updates <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (update_btb_ex) begin
        if (u_hit) begin
          if (is_jump_ex || ex_branch_taken) targets[u] <= jump_addr_ex;
          ctrs[u] <= is_jump_ex ? 2'b11
                   : ex_branch_taken ? (ctrs[u] == 2'b11 ? 2'b11 : ctrs[u] + 2'b01)
                   : (ctrs[u] == 2'b00 ? 2'b00 : ctrs[u] - 2'b01);
        end else if (ex_branch_taken || is_jump_ex) begin
          valid[u] <= 1'b1;
          tags[u] <= tag_ex;
          targets[u] <= jump_addr_ex;
          ctrs[u] <= is_jump_ex ? 2'b11 : 2'b10;
        end
      end
      // Flush is applied last so it overrides an allocation in the same cycle.
      if (flush_btb) valid <= '0;
      if (update_btb_ex) perf_updates <= perf_updates + 1'b1;
      if (modify_pc_ex) perf_mispredicts <= perf_mispredicts + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven directed checks plus reset/perf sequences.
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        btb_hit_if;
  logic        predicted_taken_if;
  logic [31:0] predicted_target_if;
  logic        update_btb_ex;
  logic [31:0] pc_ex;
  logic        ex_branch_taken;
  logic [31:0] jump_addr_ex;
  logic        is_jump_ex;
  logic        modify_pc_ex;
  logic        flush_btb;
  logic [15:0] perf_updates;
  logic [15:0] perf_mispredicts;
  int passed = 0;
  int total = 0;
  branch_target_buffer #(.ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .btb_hit_if(btb_hit_if),
    .predicted_taken_if(predicted_taken_if), .predicted_target_if(predicted_target_if),
    .update_btb_ex(update_btb_ex), .pc_ex(pc_ex), .ex_branch_taken(ex_branch_taken),
    .jump_addr_ex(jump_addr_ex), .is_jump_ex(is_jump_ex), .modify_pc_ex(modify_pc_ex),
    .flush_btb(flush_btb), .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [31:0] pcx;
    logic        tk;
    logic [31:0] ja;
    logic        jmp;
    logic        mod;
    logic        fl;
    logic        hit;
    logic        pt;
    logic [31:0] tgt;
  } vec_t;
  function automatic vec_t mk(logic [31:0] pc, logic upd, logic [31:0] pcx, logic tk,
                              logic [31:0] ja, logic jmp, logic mod, logic fl,
                              logic hit, logic pt, logic [31:0] tgt);
    vec_t v;
    v.pc = pc; v.upd = upd; v.pcx = pcx; v.tk = tk; v.ja = ja; v.jmp = jmp;
    v.mod = mod; v.fl = fl; v.hit = hit; v.pt = pt; v.tgt = tgt;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  vec_t vecs[18];
  initial begin
    // Lookups in each row see the state from before that row's update edge.
    vecs[0]  = mk(32'h100, 1, 32'h100, 1, 32'h80,  0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 1, 1, 32'h80);
    vecs[2]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 0, 1, 0, 32'h80);
    vecs[3]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 0, 1, 0, 32'h80);
    vecs[4]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h80);
    vecs[5]  = mk(32'h140, 1, 32'h140, 1, 32'h200, 0, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 32'h0);
    vecs[7]  = mk(32'h143, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h200);
    vecs[8]  = mk(32'h20,  1, 32'h20,  1, 32'h400, 1, 0, 0, 0, 0, 32'h0);
    vecs[9]  = mk(32'h20,  1, 32'h20,  0, 32'h999, 0, 1, 0, 1, 1, 32'h400);
    vecs[10] = mk(32'h20,  0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h400);
    vecs[11] = mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 0, 1, 1, 32'h200);
    vecs[12] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h300);
    vecs[13] = mk(32'h44,  1, 32'h44,  0, 32'h600, 0, 0, 0, 0, 0, 32'h0);
    vecs[14] = mk(32'h44,  0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 32'h0);
    vecs[15] = mk(32'h20,  1, 32'h20,  1, 32'h500, 1, 0, 1, 1, 1, 32'h400);
    vecs[16] = mk(32'h20,  0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 32'h0);
    vecs[17] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 32'h0);
    rst_n = 1'b0; pc_if = 32'h100; update_btb_ex = 0; pc_ex = 0; ex_branch_taken = 0;
    jump_addr_ex = 0; is_jump_ex = 0; modify_pc_ex = 0; flush_btb = 0;
    repeat (2) @(negedge clk);
    check("rst_hit", 32'(btb_hit_if), 32'h0);
    check("rst_taken", 32'(predicted_taken_if), 32'h0);
    check("rst_target", predicted_target_if, 32'h0);
    check("rst_perf_upd", 32'(perf_updates), 32'h0);
    check("rst_perf_mis", 32'(perf_mispredicts), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pc_if = vecs[i].pc; update_btb_ex = vecs[i].upd; pc_ex = vecs[i].pcx;
      ex_branch_taken = vecs[i].tk; jump_addr_ex = vecs[i].ja; is_jump_ex = vecs[i].jmp;
      modify_pc_ex = vecs[i].mod; flush_btb = vecs[i].fl;
      #1;
      check($sformatf("v%0d_hit", i), 32'(btb_hit_if), 32'(vecs[i].hit));
      check($sformatf("v%0d_taken", i), 32'(predicted_taken_if), 32'(vecs[i].pt));
      check($sformatf("v%0d_target", i), predicted_target_if, vecs[i].tgt);
      @(negedge clk);
    end
    update_btb_ex = 0; modify_pc_ex = 0; flush_btb = 0;
    #1;
    check("tbl_perf_upd", 32'(perf_updates), 32'd10);
    check("tbl_perf_mis", 32'(perf_mispredicts), 32'd2);
    // Allocate, then assert reset mid-cycle with an update pending.
    pc_if = 32'h100; pc_ex = 32'h100; ex_branch_taken = 1; jump_addr_ex = 32'h80;
    update_btb_ex = 1;
    @(negedge clk);
    update_btb_ex = 0;
    #1;
    check("pre_rst_hit", 32'(btb_hit_if), 32'h1);
    #1;
    rst_n = 1'b0; update_btb_ex = 1; modify_pc_ex = 1;
    #1;
    check("async_rst_hit", 32'(btb_hit_if), 32'h0);
    check("async_rst_taken", 32'(predicted_taken_if), 32'h0);
    check("async_rst_target", predicted_target_if, 32'h0);
    check("async_rst_upd", 32'(perf_updates), 32'h0);
    check("async_rst_mis", 32'(perf_mispredicts), 32'h0);
    @(negedge clk);
    check("rst_hold_upd", 32'(perf_updates), 32'h0);
    check("rst_hold_hit", 32'(btb_hit_if), 32'h0);
    rst_n = 1'b1; update_btb_ex = 0; modify_pc_ex = 0;
    #1;
    check("post_rst_hit", 32'(btb_hit_if), 32'h0);
    @(negedge clk);
    pc_ex = 32'h200; ex_branch_taken = 0; pc_if = 32'h200;
    for (int i = 0; i < 5; i++) begin
      update_btb_ex = 1; modify_pc_ex = (i == 1 || i == 3);
      @(negedge clk);
    end
    update_btb_ex = 0; modify_pc_ex = 0;
    #1;
    check("perf_upd5", 32'(perf_updates), 32'd5);
    check("perf_mis2", 32'(perf_mispredicts), 32'd2);
    check("nt_miss_noalloc", 32'(btb_hit_if), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
